spi_transaction_controller: RTL and testbench

- System-clock-domain sequencer for the SPI memory slave.
- Consumes conditioned chip-select and one-cycle SCLK edge pulses from the input conditioners.
- Counts bits and decodes the address/RW header.
- Drives the enables of the address latch, shift register parallel load, MISO tri-state buffer and data memory write port, with a bit counter, abort detection and a transaction counter.

---
 rtl/spi_pkg.sv | 32 +++
 rtl/spi_bit_counter.sv | 34 +++
 rtl/spi_transaction_controller.sv | 160 ++++++++++++++++
 tb/tb_spi_transaction_controller.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI memory slave transaction controller.
//   state_t         : controller state encoding (3 bits)
//   *_DEFAULT       : default frame geometry (address / data bits)
//   bit_cnt_width() : bit counter width wide enough for the longest phase
package spi_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 7;
    localparam int unsigned DATA_W_DEFAULT = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR      = 3'd1,
        DECODE    = 3'd2,
        RD_LOAD   = 3'd3,
        RD_DATA   = 3'd4,
        WR_DATA   = 3'd5,
        WR_COMMIT = 3'd6,
        DONE      = 3'd7
    } state_t;

    // Longest phase is either the header (address + R/W) or the data field.
    function automatic int unsigned bit_cnt_width(input int unsigned addr_w,
                                                  input int unsigned data_w);
        int unsigned span;
        span = ((addr_w + 1) > data_w) ? (addr_w + 1) : data_w;
        return $clog2(span) + 1;
    endfunction

    localparam int unsigned BIT_CNT_W_DEFAULT =
        bit_cnt_width(ADDR_W_DEFAULT, DATA_W_DEFAULT);

endpackage

// File: rtl/spi_bit_counter.sv
// SCLK bit counter for one frame phase.
//   clk, rst : system clock, asynchronous active-high reset
//   clear    : synchronous clear (dominates inc)
//   inc      : count one SCLK rising edge
//   terminal : number of bits in the current phase
//   count    : bits counted so far in this phase
//   last     : the next inc completes the phase
module spi_bit_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         inc,
    input  logic [W-1:0] terminal,
    output logic [W-1:0] count,
    output logic         last
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + W'(1);
        end
    end

    // Flag is raised one bit early so the FSM can leave the phase on the
    // terminal pulse itself rather than a cycle later.
    assign last = (count == (terminal - W'(1)));

endmodule

// File: rtl/spi_transaction_controller.sv
// System-clock-domain sequencer for the SPI memory slave.
//   s_clk, reset : system clock, asynchronous active-high reset
//   cs_n         : conditioned chip select, active low
//   sclk_pos     : one-cycle pulse per SCLK rising edge
//   sclk_neg     : one-cycle pulse per SCLK falling edge (observed only)
//   rw_bit       : shift register bit 0, read/write flag during DECODE
//   addr_we      : address latch write enable
//   sr_load      : shift register parallel-load enable
//   miso_en      : MISO buffer enable
//   dm_we        : data memory write enable
//   busy         : controller not idle
//   abort        : one-cycle pulse after a mid-frame chip-select release
//   xfer_count   : completed transactions, wrapping
module spi_transaction_controller
    import spi_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
    parameter int unsigned DATA_W = DATA_W_DEFAULT,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             s_clk,
    input  logic             reset,
    input  logic             cs_n,
    input  logic             sclk_pos,
    input  logic             sclk_neg,
    input  logic             rw_bit,
    output logic             addr_we,
    output logic             sr_load,
    output logic             miso_en,
    output logic             dm_we,
    output logic             busy,
    output logic             abort,
    output logic [CNT_W-1:0] xfer_count
);

    localparam int unsigned BIT_CNT_W = bit_cnt_width(ADDR_W, DATA_W);

    state_t               state;
    state_t               state_nxt;
    logic                 cnt_clear;
    logic                 cnt_inc;
    logic                 cnt_last;
    logic [BIT_CNT_W-1:0] cnt_terminal;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic                 abort_nxt;
    logic                 done_entry;

    // Counter only runs in the bit-shifting phases; holding it clear elsewhere
    // gives the "cleared on entry" behaviour for ADDR and both data phases.
    always_comb begin
        cnt_clear    = !(state inside {ADDR, RD_DATA, WR_DATA});
        cnt_inc      = sclk_pos && !cnt_clear;
        cnt_terminal = (state == ADDR) ? BIT_CNT_W'(ADDR_W + 1) : BIT_CNT_W'(DATA_W);
    end

    spi_bit_counter #(
        .W (BIT_CNT_W)
    ) u_bit_counter (
        .clk      (s_clk),
        .rst      (reset),
        .clear    (cnt_clear),
        .inc      (cnt_inc),
        .terminal (cnt_terminal),
        .count    (bit_cnt),
        .last     (cnt_last)
    );

    always_ff @(posedge s_clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Chip-select release is checked before the terminal pulse in every
    // abortable state, so a simultaneous release and final bit aborts.
    always_comb begin
        state_nxt = state;
        abort_nxt = 1'b0;
        unique case (state)
            IDLE: begin
                if (!cs_n) state_nxt = ADDR;
            end
            ADDR: begin
                if (cs_n) begin
                    state_nxt = IDLE;
                    abort_nxt = 1'b1;
                end else if (sclk_pos && cnt_last) begin
                    state_nxt = DECODE;
                end
            end
            DECODE: begin
                if (cs_n) begin
                    state_nxt = IDLE;
                    abort_nxt = 1'b1;
                end else begin
                    state_nxt = rw_bit ? RD_LOAD : WR_DATA;
                end
            end
            RD_LOAD: begin
                state_nxt = RD_DATA;
                if (cs_n) begin
                    state_nxt = IDLE;
                    abort_nxt = 1'b1;
                end
            end
            RD_DATA: begin
                if (cs_n) begin
                    state_nxt = IDLE;
                    abort_nxt = 1'b1;
                end else if (sclk_pos && cnt_last) begin
                    state_nxt = DONE;
                end
            end
            WR_DATA: begin
                if (cs_n) begin
                    state_nxt = IDLE;
                    abort_nxt = 1'b1;
                end else if (sclk_pos && cnt_last) begin
                    state_nxt = WR_COMMIT;
                end
            end
            WR_COMMIT: begin
                state_nxt = DONE;
            end
            DONE: begin
                if (cs_n) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign done_entry = (state_nxt == DONE) && (state != DONE);

    always_ff @(posedge s_clk or posedge reset) begin
        if (reset) begin
            abort      <= 1'b0;
            xfer_count <= '0;
        end else begin
            abort <= abort_nxt;
            if (done_entry) xfer_count <= xfer_count + CNT_W'(1);
        end
    end

    always_comb begin
        addr_we = (state == DECODE);
        sr_load = (state == RD_LOAD);
        miso_en = (state == RD_LOAD) || (state == RD_DATA);
        dm_we   = (state == WR_COMMIT);
        busy    = (state != IDLE);
    end

    // sclk_neg has no state effect here; bit_cnt is exposed for debug probing.
    logic unused_observe;
    assign unused_observe = sclk_neg ^ (^bit_cnt);

endmodule

// File: tb/tb_spi_transaction_controller.sv
module tb_spi_transaction_controller;

    logic       s_clk = 1'b0;
    logic       reset;
    logic       cs_n;
    logic       sclk_pos;
    logic       sclk_neg;
    logic       rw_bit;
    logic       addr_we;
    logic       sr_load;
    logic       miso_en;
    logic       dm_we;
    logic       busy;
    logic       abort;
    logic [7:0] xfer_count;

    int checks = 0;
    int errors = 0;

    // Reference model: completed transactions modulo 2^CNT_W.
    int unsigned model_xfer = 0;

    // Running totals of asserted-cycles per output, written only here.
    int n_addr_we = 0;
    int n_sr_load = 0;
    int n_miso    = 0;
    int n_dm_we   = 0;
    int n_abort   = 0;
    int n_busy    = 0;

    spi_transaction_controller #(
        .ADDR_W (7),
        .DATA_W (8),
        .CNT_W  (8)
    ) dut (
        .s_clk      (s_clk),
        .reset      (reset),
        .cs_n       (cs_n),
        .sclk_pos   (sclk_pos),
        .sclk_neg   (sclk_neg),
        .rw_bit     (rw_bit),
        .addr_we    (addr_we),
        .sr_load    (sr_load),
        .miso_en    (miso_en),
        .dm_we      (dm_we),
        .busy       (busy),
        .abort      (abort),
        .xfer_count (xfer_count)
    );

    always #5 s_clk = ~s_clk;

    always @(negedge s_clk) begin
        if (addr_we) n_addr_we++;
        if (sr_load) n_sr_load++;
        if (miso_en) n_miso++;
        if (dm_we)   n_dm_we++;
        if (abort)   n_abort++;
        if (busy)    n_busy++;
    end

    task automatic step();
        @(posedge s_clk);
        #1;
    endtask

    // One frame: header of 8 bits then 8 data bits. abort_at = k (1..16)
    // raises cs_n together with pulse k; n_extra pulses are sent in DONE.
    task automatic run_frame(input bit rw, input int abort_at, input int n_extra,
                             input int max_gap);
        int  a0, s0, m0, d0, ab0;
        int  exp_addr, exp_sr, exp_dm, exp_ab;
        bit  cut;
        bit  aborted;
        aborted = 1'b0;
        a0 = n_addr_we; s0 = n_sr_load; m0 = n_miso; d0 = n_dm_we; ab0 = n_abort;
        cs_n   = 1'b0;
        rw_bit = 1'($urandom_range(0, 1));
        step();
        repeat ($urandom_range(0, 2)) step();
        for (int p = 1; p <= 16; p++) begin
            cut = (abort_at == p);
            sclk_pos = 1'b1;
            if (p == 8) rw_bit = rw;
            if (cut) cs_n = 1'b1;
            step();
            sclk_pos = 1'b0;
            if (cut) begin
                checks++;
                if (abort !== 1'b1 || busy !== 1'b0 || dm_we !== 1'b0) begin
                    errors++;
                    $display("FAIL abort_edge p=%0d: abort=%b busy=%b dm_we=%b want 1 0 0",
                             p, abort, busy, dm_we);
                end
                step();
                checks++;
                if (abort !== 1'b0) begin
                    errors++;
                    $display("FAIL abort_width: abort=%b want 0", abort);
                end
                aborted = 1'b1;
                break;
            end
            if (p == 8) begin
                checks++;
                if (addr_we !== 1'b1) begin
                    errors++;
                    $display("FAIL addr_we_latency: addr_we=%b want 1", addr_we);
                end
            end
            if (p == 16) begin
                checks++;
                if (dm_we !== !rw || miso_en !== 1'b0) begin
                    errors++;
                    $display("FAIL end_of_data rw=%0d: dm_we=%b miso_en=%b want %b 0",
                             rw, dm_we, miso_en, !rw);
                end
            end
            sclk_neg = 1'b1;
            step();
            sclk_neg = 1'b0;
            if (p == 8 && rw) begin
                checks++;
                if (sr_load !== 1'b1 || miso_en !== 1'b1 || addr_we !== 1'b0) begin
                    errors++;
                    $display("FAIL rd_load: sr_load=%b miso_en=%b addr_we=%b want 1 1 0",
                             sr_load, miso_en, addr_we);
                end
            end
            if (p == 15) begin
                checks++;
                if (miso_en !== rw || dm_we !== 1'b0) begin
                    errors++;
                    $display("FAIL data_phase rw=%0d: miso_en=%b dm_we=%b want %b 0",
                             rw, miso_en, dm_we, rw);
                end
            end
            repeat ($urandom_range(1, max_gap)) step();
        end

        if (!aborted) begin
            model_xfer = (model_xfer + 1) % 256;
            if (n_extra > 0) begin
                int ea, es, em, ed;
                ea = n_addr_we; es = n_sr_load; em = n_miso; ed = n_dm_we;
                for (int e = 0; e < n_extra; e++) begin
                    sclk_pos = 1'b1;
                    step();
                    sclk_pos = 1'b0;
                    repeat (2) step();
                end
                checks++;
                if (n_addr_we != ea || n_sr_load != es || n_miso != em ||
                    n_dm_we != ed || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL done_extra: enable cycles %0d/%0d/%0d/%0d busy=%b want 0 0 0 0 busy 1",
                             n_addr_we - ea, n_sr_load - es, n_miso - em, n_dm_we - ed, busy);
                end
            end
            cs_n = 1'b1;
            step();
            checks++;
            if (busy !== 1'b0 || abort !== 1'b0) begin
                errors++;
                $display("FAIL release_idle: busy=%b abort=%b want 0 0", busy, abort);
            end
        end
        step();

        exp_addr = (abort_at == 0 || abort_at > 8) ? 1 : 0;
        exp_sr   = (rw && exp_addr == 1) ? 1 : 0;
        exp_dm   = (!rw && abort_at == 0) ? 1 : 0;
        exp_ab   = (abort_at != 0) ? 1 : 0;
        checks++;
        if (n_addr_we - a0 != exp_addr || n_sr_load - s0 != exp_sr ||
            n_dm_we - d0 != exp_dm || n_abort - ab0 != exp_ab) begin
            errors++;
            $display("FAIL frame_events rw=%0d abort_at=%0d: addr_we=%0d sr_load=%0d dm_we=%0d abort=%0d want %0d %0d %0d %0d",
                     rw, abort_at, n_addr_we - a0, n_sr_load - s0, n_dm_we - d0,
                     n_abort - ab0, exp_addr, exp_sr, exp_dm, exp_ab);
        end
        if (!rw || exp_addr == 0) begin
            checks++;
            if (n_miso != m0) begin
                errors++;
                $display("FAIL miso_quiet rw=%0d: miso_en cycles=%0d want 0", rw, n_miso - m0);
            end
        end
        checks++;
        if (xfer_count !== model_xfer[7:0]) begin
            errors++;
            $display("FAIL xfer_count: got %0d want %0d", xfer_count, model_xfer);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; cs_n = 1'b1; sclk_pos = 1'b0; sclk_neg = 1'b0; rw_bit = 1'b0;
        repeat (3) step();
        checks++;
        if ({addr_we, sr_load, miso_en, dm_we, busy, abort} !== 6'b0 || xfer_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: outs=%b xfer=%0d want 000000 0",
                     {addr_we, sr_load, miso_en, dm_we, busy, abort}, xfer_count);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_write();
        run_frame(1'b0, 0, 0, 3);
    endtask

    task automatic test_read();
        run_frame(1'b1, 0, 0, 3);
    endtask

    task automatic test_reset_mid_write();
        int d0, b0;
        cs_n = 1'b0;
        step();
        for (int p = 1; p <= 12; p++) begin
            sclk_pos = 1'b1;
            if (p == 8) rw_bit = 1'b0;
            step();
            sclk_pos = 1'b0;
            repeat (3) step();
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({addr_we, sr_load, miso_en, dm_we, busy, abort} !== 6'b0 || xfer_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid_frame: outs=%b xfer=%0d want 000000 0",
                     {addr_we, sr_load, miso_en, dm_we, busy, abort}, xfer_count);
        end
        model_xfer = 0;
        step();
        cs_n  = 1'b1;
        reset = 1'b0;
        step();
        d0 = n_dm_we; b0 = n_busy;
        for (int p = 0; p < 4; p++) begin
            sclk_pos = 1'b1;
            step();
            sclk_pos = 1'b0;
            repeat (3) step();
        end
        checks++;
        if (n_dm_we != d0 || n_busy != b0 || xfer_count !== 8'd0) begin
            errors++;
            $display("FAIL post_reset_pulses: dm_we=%0d busy=%0d xfer=%0d want 0 0 0",
                     n_dm_we - d0, n_busy - b0, xfer_count);
        end
    endtask

    task automatic test_abort_addr();
        run_frame(1'($urandom_range(0, 1)), 5, 0, 3);
        run_frame(1'b0, 0, 0, 3);
    endtask

    task automatic test_boundary_last_pulse();
        run_frame(1'b0, 16, 0, 3);
        run_frame(1'b1, 16, 0, 3);
    endtask

    task automatic test_idle_pulses();
        int b0;
        b0 = n_busy;
        cs_n = 1'b1;
        for (int p = 0; p < 20; p++) begin
            sclk_pos = 1'b1;
            step();
            sclk_pos = 1'b0;
            repeat ($urandom_range(1, 3)) step();
        end
        checks++;
        if (n_busy != b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_pulses: busy cycles=%0d busy=%b want 0 0", n_busy - b0, busy);
        end
    endtask

    task automatic test_done_extra();
        run_frame(1'b0, 0, 3, 3);
        run_frame(1'b1, 0, 3, 3);
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            int ab;
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 16)) : 0;
            run_frame(1'($urandom_range(0, 1)), ab, int'($urandom_range(0, 3)),
                      int'($urandom_range(1, 5)));
        end
    endtask

    task automatic test_wrap();
        while (model_xfer != 255) run_frame(1'($urandom_range(0, 1)), 0, 0, 1);
        checks++;
        if (xfer_count !== 8'd255) begin
            errors++;
            $display("FAIL preload_255: got %0d want 255", xfer_count);
        end
        run_frame(1'b0, 0, 0, 1);
        checks++;
        if (xfer_count !== 8'd0) begin
            errors++;
            $display("FAIL wrap: got %0d want 0", xfer_count);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_reset_mid_write();
        test_abort_addr();
        test_boundary_last_pulse();
        test_idle_pulses();
        test_done_extra();
        test_random();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
